// File: rtl/rf_write_sched_if.sv
// ----------------------------------------------------------------------------
// rf_write_sched_if
// Bundles every non-clock/reset signal of the register-file write scheduler.
//   ALU writeback   : alu_wr_valid/alu_wr_addr/alu_wr_data in, alu_wr_ready out
//   Load return     : mem_wr_valid/mem_wr_addr/mem_wr_data in (always accepted)
//   Load issue      : load_issue/load_issue_addr in (marks destination busy)
//   Decode reads    : rd_addrA/rd_addrB in, stall out
//   RF write port   : rf_we/rf_waddr/rf_wdata out (registered)
//   Scoreboard      : busy_vec out
//   Statistics      : conflict_cnt out, present only with RF_WSCHED_STATS_EN
// Modport slave is the scheduler side; modport master is the driving side.
// ----------------------------------------------------------------------------
interface rf_write_sched_if #(
   parameter int W = 8,
   parameter int D = 4
);
   logic                alu_wr_valid;
   logic [D-1:0]        alu_wr_addr;
   logic [W-1:0]        alu_wr_data;
   logic                alu_wr_ready;
   logic                mem_wr_valid;
   logic [D-1:0]        mem_wr_addr;
   logic [W-1:0]        mem_wr_data;
   logic                load_issue;
   logic [D-1:0]        load_issue_addr;
   logic [D-1:0]        rd_addrA;
   logic [D-1:0]        rd_addrB;
   logic                stall;
   logic                rf_we;
   logic [D-1:0]        rf_waddr;
   logic [W-1:0]        rf_wdata;
   logic [(2**D)-1:0]   busy_vec;
`ifdef RF_WSCHED_STATS_EN
   logic [7:0]          conflict_cnt;
`endif

   modport slave (
`ifdef RF_WSCHED_STATS_EN
      output conflict_cnt,
`endif
      input  alu_wr_valid, alu_wr_addr, alu_wr_data,
      input  mem_wr_valid, mem_wr_addr, mem_wr_data,
      input  load_issue, load_issue_addr,
      input  rd_addrA, rd_addrB,
      output alu_wr_ready, stall,
      output rf_we, rf_waddr, rf_wdata, busy_vec
   );

   modport master (
`ifdef RF_WSCHED_STATS_EN
      input  conflict_cnt,
`endif
      output alu_wr_valid, alu_wr_addr, alu_wr_data,
      output mem_wr_valid, mem_wr_addr, mem_wr_data,
      output load_issue, load_issue_addr,
      output rd_addrA, rd_addrB,
      input  alu_wr_ready, stall,
      input  rf_we, rf_waddr, rf_wdata, busy_vec
   );
endinterface

// File: rtl/rf_write_sched.sv
// ----------------------------------------------------------------------------
// rf_write_sched
// Arbitrates the single write port of the register file between load returns
// (always win) and ALU writebacks (deferred in an in-order queue when they
// lose), tracks outstanding loads in a scoreboard and raises a decode stall on
// read hazards.
// Ports:
//   clk_i    : clock, all state on rising edge
//   rst_n_i  : synchronous active-low reset
//   bus      : rf_write_sched_if.slave (handshakes, RF write port, stall,
//              scoreboard)
// Optional: define RF_WSCHED_STATS_EN to add the saturating conflict_cnt
// output counting ALU writes that did not go straight to the port.
// ----------------------------------------------------------------------------
module rf_write_sched #(
   parameter int W  = 8,
   parameter int D  = 4,
   parameter int QD = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   rf_write_sched_if.slave  bus
);
   localparam int           AW      = $clog2(QD);
   localparam int           NR      = 2**D;
   localparam logic [AW:0]  QD_FULL = (AW+1)'(QD);

   logic [D-1:0]   q_addr_q [QD];
   logic [W-1:0]   q_data_q [QD];
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           rf_we_q, rf_we_d;
   logic [D-1:0]   rf_waddr_q, rf_waddr_d;
   logic [W-1:0]   rf_wdata_q, rf_wdata_d;
   logic [NR-1:0]  busy_q, busy_d;

   logic           ready_s, accept_s, q_empty_s;
   logic           enq_s, deq_s, direct_s;
   logic [NR-1:0]  set_mask_s, clr_mask_s;
   logic [QD-1:0]  q_live_s;
   logic           stall_s;

   // Port grant: mem return, else queue head, else a direct ALU write.
   always_comb begin
      ready_s    = (count_q != QD_FULL);
      accept_s   = bus.alu_wr_valid & ready_s;
      q_empty_s  = (count_q == {(AW+1){1'b0}});
      rf_we_d    = 1'b0;
      rf_waddr_d = {D{1'b0}};
      rf_wdata_d = {W{1'b0}};
      enq_s      = 1'b0;
      deq_s      = 1'b0;
      direct_s   = 1'b0;
      if (bus.mem_wr_valid) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = bus.mem_wr_addr;
         rf_wdata_d = bus.mem_wr_data;
         enq_s      = accept_s;
      end else if (!q_empty_s) begin
         // Accepted ALU write queues behind the head to keep issue order.
         rf_we_d    = 1'b1;
         rf_waddr_d = q_addr_q[rd_ptr_q];
         rf_wdata_d = q_data_q[rd_ptr_q];
         deq_s      = 1'b1;
         enq_s      = accept_s;
      end else if (accept_s) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = bus.alu_wr_addr;
         rf_wdata_d = bus.alu_wr_data;
         direct_s   = 1'b1;
      end else begin
         rf_we_d    = 1'b0;
      end
   end

   // Queue pointer/count and scoreboard next state; set is applied after clear.
   always_comb begin
      count_d    = count_q + (AW+1)'(enq_s) - (AW+1)'(deq_s);
      wr_ptr_d   = enq_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d   = deq_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      clr_mask_s = bus.mem_wr_valid ? ({{(NR-1){1'b0}}, 1'b1} << bus.mem_wr_addr) : {NR{1'b0}};
      set_mask_s = bus.load_issue   ? ({{(NR-1){1'b0}}, 1'b1} << bus.load_issue_addr) : {NR{1'b0}};
      busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
   end

   // Read-hazard detection against scoreboard, live queue slots and the
   // write currently on the RF port (not yet visible to the read path).
   always_comb begin
      stall_s = busy_q[bus.rd_addrA] | busy_q[bus.rd_addrB];
      stall_s = stall_s | (rf_we_q & ((rf_waddr_q == bus.rd_addrA) | (rf_waddr_q == bus.rd_addrB)));
      for (int i = 0; i < QD; i++) begin
         // Slot i is live when its distance from the head is below count.
         q_live_s[i] = ({1'b0, AW'(AW'(i) - rd_ptr_q)} < count_q);
         stall_s     = stall_s | (q_live_s[i] & ((q_addr_q[i] == bus.rd_addrA) | (q_addr_q[i] == bus.rd_addrB)));
      end
   end

   // State registers: queue, RF write port, scoreboard.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_ptr_q   <= {AW{1'b0}};
         wr_ptr_q   <= {AW{1'b0}};
         count_q    <= {(AW+1){1'b0}};
         rf_we_q    <= 1'b0;
         rf_waddr_q <= {D{1'b0}};
         rf_wdata_q <= {W{1'b0}};
         busy_q     <= {NR{1'b0}};
         for (int i = 0; i < QD; i++) begin
            q_addr_q[i] <= {D{1'b0}};
            q_data_q[i] <= {W{1'b0}};
         end
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
         if (enq_s) begin
            q_addr_q[wr_ptr_q] <= bus.alu_wr_addr;
            q_data_q[wr_ptr_q] <= bus.alu_wr_data;
         end else begin
            q_addr_q[wr_ptr_q] <= q_addr_q[wr_ptr_q];
            q_data_q[wr_ptr_q] <= q_data_q[wr_ptr_q];
         end
      end
   end

   assign bus.alu_wr_ready = ready_s;
   assign bus.stall        = stall_s;
   assign bus.rf_we        = rf_we_q;
   assign bus.rf_waddr     = rf_waddr_q;
   assign bus.rf_wdata     = rf_wdata_q;
   assign bus.busy_vec     = busy_q;

`ifdef RF_WSCHED_STATS_EN
   logic [7:0] conflict_q;

   // Saturating count of ALU writes that were queued or refused.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         conflict_q <= 8'd0;
      end else if (bus.alu_wr_valid && !direct_s && (conflict_q != 8'hFF)) begin
         conflict_q <= conflict_q + 8'd1;
      end else begin
         conflict_q <= conflict_q;
      end
   end

   assign bus.conflict_cnt = conflict_q;
`else
`endif
endmodule

// File: tb/tb_rf_write_sched.sv
module tb_rf_write_sched;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int QD = 2;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   rf_write_sched_if #(.W(W), .D(D)) bus ();

   rf_write_sched #(.W(W), .D(D), .QD(QD)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: list of deferred ALU writes plus scoreboard and port.
   wr_t         mq[$];
   logic [15:0] m_busy  = 16'h0;
   logic        m_we    = 1'b0;
   logic [3:0]  m_waddr = 4'h0;
   logic [7:0]  m_wdata = 8'h0;
   int          m_conf  = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_hz(logic [3:0] a);
      logic h;
      h = m_busy[a] || (m_we && (m_waddr == a));
      foreach (mq[i]) begin
         if (mq[i].a == a) h = 1'b1;
      end
      return h;
   endfunction

   task automatic clr_inputs();
      bus.alu_wr_valid    = 1'b0;
      bus.alu_wr_addr     = 4'h0;
      bus.alu_wr_data     = 8'h0;
      bus.mem_wr_valid    = 1'b0;
      bus.mem_wr_addr     = 4'h0;
      bus.mem_wr_data     = 8'h0;
      bus.load_issue      = 1'b0;
      bus.load_issue_addr = 4'h0;
   endtask

   // One clock: check combinational outputs, advance model, check registers.
   task automatic tick();
      logic rdy, acc, direct;
      wr_t  h;
      #1;
      rdy = (mq.size() < QD);
      chk("alu_wr_ready", bus.alu_wr_ready, rdy);
      chk("stall", bus.stall, m_hz(bus.rd_addrA) || m_hz(bus.rd_addrB));
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_busy = 16'h0; m_we = 1'b0; m_waddr = 4'h0; m_wdata = 8'h0; m_conf = 0;
      end else begin
         acc    = bus.alu_wr_valid && rdy;
         direct = 1'b0;
         if (bus.mem_wr_valid) begin
            m_we = 1'b1; m_waddr = bus.mem_wr_addr; m_wdata = bus.mem_wr_data;
            if (acc) mq.push_back({bus.alu_wr_addr, bus.alu_wr_data});
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = 1'b1; m_waddr = h.a; m_wdata = h.d;
            if (acc) mq.push_back({bus.alu_wr_addr, bus.alu_wr_data});
         end else if (acc) begin
            m_we = 1'b1; m_waddr = bus.alu_wr_addr; m_wdata = bus.alu_wr_data;
            direct = 1'b1;
         end else begin
            m_we = 1'b0;
         end
         if (bus.alu_wr_valid && !direct && m_conf < 255) m_conf++;
         if (bus.mem_wr_valid) m_busy[bus.mem_wr_addr] = 1'b0;
         if (bus.load_issue)   m_busy[bus.load_issue_addr] = 1'b1;
      end
      #1;
      chk("rf_we", bus.rf_we, m_we);
      if (m_we) begin
         chk("rf_waddr", bus.rf_waddr, m_waddr);
         chk("rf_wdata", bus.rf_wdata, m_wdata);
      end
      chk("busy_vec", bus.busy_vec, m_busy);
`ifdef RF_WSCHED_STATS_EN
      chk("conflict_cnt", bus.conflict_cnt, m_conf);
`endif
   endtask

   initial begin
      logic ok;
      clr_inputs();
      bus.rd_addrA = 4'h3;
      bus.rd_addrB = 4'h5;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tick();

      // Reset then idle
      rst_n = 1'b1;
      tick();
      chk("idle_rf_we", bus.rf_we, 1'b0);
      chk("idle_busy", bus.busy_vec, 16'h0);
      chk("idle_ready", bus.alu_wr_ready, 1'b1);
      chk("idle_stall", bus.stall, 1'b0);

      // Lone ALU write goes direct
      bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'h2; bus.alu_wr_data = 8'h5A;
      tick();
      chk("direct_we", bus.rf_we, 1'b1);
      chk("direct_addr", bus.rf_waddr, 4'h2);
      chk("direct_data", bus.rf_wdata, 8'h5A);
      clr_inputs();
      tick();
      chk("direct_we_off", bus.rf_we, 1'b0);

      // Mem and ALU collide: mem first, ALU next cycle
      bus.rd_addrA = 4'h3;
      bus.mem_wr_valid = 1'b1; bus.mem_wr_addr = 4'h7; bus.mem_wr_data = 8'h11;
      bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'h3; bus.alu_wr_data = 8'h22;
      tick();
      chk("collide_mem_addr", bus.rf_waddr, 4'h7);
      chk("collide_stall_q", bus.stall, 1'b1);
      clr_inputs();
      tick();
      chk("collide_alu_addr", bus.rf_waddr, 4'h3);
      chk("collide_alu_data", bus.rf_wdata, 8'h22);
      chk("collide_stall_we", bus.stall, 1'b1);
      tick();

      // Queue fills under three mem cycles; third ALU write refused
      bus.rd_addrA = 4'h0; bus.rd_addrB = 4'h0;
      bus.mem_wr_valid = 1'b1; bus.mem_wr_addr = 4'h8; bus.mem_wr_data = 8'hA1;
      bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'h1; bus.alu_wr_data = 8'h01;
      tick();
      bus.mem_wr_addr = 4'h9; bus.mem_wr_data = 8'hA2;
      bus.alu_wr_addr = 4'h4; bus.alu_wr_data = 8'h04;
      tick();
      chk("full_ready", bus.alu_wr_ready, 1'b0);
      bus.mem_wr_addr = 4'hA; bus.mem_wr_data = 8'hA3;
      bus.alu_wr_addr = 4'h6; bus.alu_wr_data = 8'h06;
      tick();
      bus.mem_wr_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         ok = (mq.size() < QD);
         tick();
      end
      chk("retry_accepted", ok, 1'b1);
      clr_inputs();
      repeat (4) tick();

      // Scoreboard: load r7 in flight, then its return
      bus.rd_addrA = 4'h7;
      bus.load_issue = 1'b1; bus.load_issue_addr = 4'h7;
      tick();
      bus.load_issue = 1'b0;
      tick();
      chk("load_busy", bus.busy_vec[7], 1'b1);
      chk("load_stall", bus.stall, 1'b1);
      bus.mem_wr_valid = 1'b1; bus.mem_wr_addr = 4'h7; bus.mem_wr_data = 8'h99;
      tick();
      chk("ret_busy_clr", bus.busy_vec[7], 1'b0);
      chk("ret_data", bus.rf_wdata, 8'h99);
      chk("ret_stall_we", bus.stall, 1'b1);
      clr_inputs();
      tick();
      chk("ret_stall_off", bus.stall, 1'b0);
      bus.load_issue = 1'b1; bus.load_issue_addr = 4'h7;
      bus.mem_wr_valid = 1'b1; bus.mem_wr_addr = 4'h7; bus.mem_wr_data = 8'h55;
      tick();
      chk("set_wins", bus.busy_vec[7], 1'b1);

      // Reset drops queued writes and scoreboard
      clr_inputs();
      bus.rd_addrA = 4'h1; bus.rd_addrB = 4'h2;
      bus.mem_wr_valid = 1'b1; bus.mem_wr_addr = 4'h9; bus.mem_wr_data = 8'hB0;
      bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'h1; bus.alu_wr_data = 8'hC1;
      tick();
      bus.mem_wr_addr = 4'hA;
      bus.alu_wr_addr = 4'h2; bus.alu_wr_data = 8'hC2;
      tick();
      chk("pre_rst_busy", bus.busy_vec, 16'h0080);
      chk("pre_rst_full", bus.alu_wr_ready, 1'b0);
      clr_inputs();
      rst_n = 1'b0;
      tick();
      chk("rst_busy", bus.busy_vec, 16'h0);
      chk("rst_we", bus.rf_we, 1'b0);
      chk("rst_ready", bus.alu_wr_ready, 1'b1);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_no_drain", bus.rf_we, 1'b0);
      end

`ifdef RF_WSCHED_STATS_EN
      // Conflict counter: one conflict, then saturation
      bus.mem_wr_valid = 1'b1; bus.mem_wr_addr = 4'h7; bus.mem_wr_data = 8'h11;
      bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'h3; bus.alu_wr_data = 8'h22;
      tick();
      chk("conf_one", bus.conflict_cnt, 8'd1);
      repeat (300) tick();
      chk("conf_sat", bus.conflict_cnt, 8'd255);
      clr_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst_n                = ($urandom_range(0, 99) != 0);
         bus.alu_wr_valid     = ($urandom_range(0, 99) < 60);
         bus.alu_wr_addr      = 4'($urandom_range(0, 15));
         bus.alu_wr_data      = 8'($urandom);
         bus.mem_wr_valid     = ($urandom_range(0, 99) < 35);
         bus.mem_wr_addr      = 4'($urandom_range(0, 15));
         bus.mem_wr_data      = 8'($urandom);
         bus.load_issue       = ($urandom_range(0, 99) < 20);
         bus.load_issue_addr  = 4'($urandom_range(0, 15));
         bus.rd_addrA         = 4'($urandom_range(0, 15));
         bus.rd_addrB         = 4'($urandom_range(0, 15));
         tick();
      end
      clr_inputs();
      rst_n = 1'b1;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
- Schedules the single write port of the 16x8 register file.
- Two producers share it: ALU writeback and memory-load return (the path that targets $t7 and other load destinations).
- Mem returns always win the port. ALU writes that lose are held in a small in-order defer queue.
- A load scoreboard plus pending-write compare drives a read-hazard stall to the decode stage.

Parameters:
- W, 8, data width of one register.
- D, 4, register address width (2**D registers).
- QD, 2, defer-queue depth for ALU writes (power of two, >=2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- alu_wr_valid  input  1  ALU has a writeback this cycle.
- alu_wr_addr  input  D  ALU destination register.
- alu_wr_data  input  W  ALU result.
- alu_wr_ready  output  1  ALU writeback accepted (combinational, = !q_full).
- mem_wr_valid  input  1  load data returning this cycle (always accepted).
- mem_wr_addr  input  D  load destination register.
- mem_wr_data  input  W  load data.
- load_issue  input  1  a load was issued; mark destination busy.
- load_issue_addr  input  D  destination of the issued load.
- rd_addrA  input  D  decode-stage read address A.
- rd_addrB  input  D  decode-stage read address B.
- stall  output  1  read hazard; decode must hold (combinational).
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  D  register-file write address (registered).
- rf_wdata  output  W  register-file write data (registered).
- busy_vec  output  2**D  scoreboard, bit i = register i awaiting load.

Behaviour:
- Reset (rst_n=0 at edge): rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, queue emptied (count=0, rd/wr pointers 0). Any pending or queued write is dropped. Reset overrides every other input that cycle.
- ALU accept: accepted = alu_wr_valid & alu_wr_ready. alu_wr_ready = (count != QD). A full queue refuses even if it drains the same cycle.
- Per-cycle port grant, exactly one source, priority order:
  1. mem_wr_valid: mem write.
  2. else queue non-empty: queue head (dequeue).
  3. else accepted ALU: ALU write direct.
- Queueing: an accepted ALU write is enqueued if it did not get the port. This covers both "mem won" and "queue non-empty", so ALU writes commit in issue order.
- Queue counter: count += enq - deq. Simultaneous enq+deq leaves count unchanged. Pointers wrap modulo QD.
- Latency:
  - Winning source appears on rf_we/rf_waddr/rf_wdata the cycle after the grant.
  - The register file captures it on the following edge.
  - rf_we=0 in any cycle with no grant.
  - ALU direct write: 1 cycle accept-to-rf_we. Each queued slot ahead adds >=1 cycle.
- Scoreboard:
  - load_issue sets busy[load_issue_addr]; a granted mem write clears busy[mem_wr_addr].
  - Set and clear of the same register in one cycle: set wins.
  - load_issue with a register already busy: stays 1.
- stall = 1 when any of the following is true for rd_addrA or rd_addrB:
  - busy[addr];
  - a valid queue entry holds addr;
  - rf_we=1 and rf_waddr == addr (write not yet visible to the combinational read).
  - Register 0 is not special.
- Mem write to a register also held in the queue: both commit in grant order. The later grant wins in the register file; no merging.

Optional Feature:
- Macro: RF_WSCHED_STATS_EN.
- Defined: adds output conflict_cnt [7:0], reset to 0. It increments (saturating at 255) each cycle in which alu_wr_valid=1 and the ALU write did not go direct, i.e. it was enqueued or refused.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle: all outputs 0, alu_wr_ready=1, stall=0 with rd_addrA=3, rd_addrB=5.
- ALU write r2=0x5A alone, queue empty -> next cycle rf_we=1, rf_waddr=2, rf_wdata=0x5A; one cycle later rf_we=0.
- Same cycle mem r7=0x11 and ALU r3=0x22 -> cycle+1 writes r7=0x11, cycle+2 writes r3=0x22; stall=1 for rd_addrA=3 during both cycles.
- Mem valid 3 consecutive cycles while ALU writes r1, r4, r6 -> alu_wr_ready drops to 0 on 3rd ALU write (r6 refused); after mem stops, r1 then r4 commit in order; ALU retries r6 and commits after them.
- load_issue r7, rd_addrA=7 -> stall=1 and busy_vec[7]=1 until mem returns r7=0x99; busy_vec[7] clears that edge; stall=0 once rf_we for r7 retires. Also check same-cycle load_issue r7 + mem r7 return: busy_vec[7] stays 1.
- Assert rst_n=0 with 2 queued entries and busy_vec=0x0080 -> next cycle count=0, busy_vec=0, rf_we=0, and no queued write ever appears.
- With RF_WSCHED_STATS_EN: the mem/ALU conflict case above increments conflict_cnt by 1; 300 forced conflicts -> conflict_cnt=255.
